// File: rtl/btn_evt_pkg.sv
// Shared types for the push-button event controller.
package btn_evt_pkg;

  // Event codes as presented on the event stream.
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_code_t;

  // Per-channel button state; IDLE means committed level 0.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_fsm_t;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce, hold counter and press/long/release FSM.
module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 1000,
  parameter int unsigned LONG_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_in,
  output logic       level,
  output logic       evt_stb,
  output logic [1:0] evt_code
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [1:0]        r_sync;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DB_W-1:0]   w_db_cnt_d;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_d;
  btn_fsm_t          r_state;
  btn_fsm_t          w_state_d;
  evt_code_t         w_code;
  logic              w_s;
  logic              w_diff;
  logic              w_commit;

  assign w_s      = r_sync[1];
  assign level    = (r_state != IDLE);
  assign w_diff   = (w_s != level);
  assign w_commit = w_diff && (r_db_cnt == DB_LAST);
  assign evt_code = w_code;

  // Two-flop synchroniser for the raw pad level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], btn_in};
  end

  // Debounce count: any agreeing cycle restarts it; it also clears on commit.
  always_comb begin
    w_db_cnt_d = '0;
    if (w_diff && !w_commit) w_db_cnt_d = r_db_cnt + 1'b1;
  end

  // FSM next state, hold counter and event strobe.
  always_comb begin
    w_state_d    = r_state;
    w_hold_cnt_d = r_hold_cnt;
    evt_stb      = 1'b0;
    w_code       = EVT_PRESS;
    unique case (r_state)
      IDLE: begin
        if (w_commit) begin
          w_state_d    = PRESSED;
          w_hold_cnt_d = '0;
          evt_stb      = 1'b1;
          w_code       = EVT_PRESS;
        end
      end
      PRESSED: begin
        if (w_commit) begin
          w_state_d = IDLE;
          evt_stb   = 1'b1;
          w_code    = EVT_RELEASE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_d = LONG_HELD;
          evt_stb   = 1'b1;
          w_code    = EVT_LONG;
        end else begin
          w_hold_cnt_d = r_hold_cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (w_commit) begin
          w_state_d = IDLE;
          evt_stb   = 1'b1;
          w_code    = EVT_RELEASE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // State, debounce and hold registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_db_cnt   <= w_db_cnt_d;
      r_hold_cnt <= w_hold_cnt_d;
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-channel button controller: per-channel pending slots, round-robin arbiter, event FIFO.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned DB_CYCLES   = 1000,
  parameter int unsigned LONG_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned ID_W       = id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_code,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [N_BTN-1:0] w_stb;
  logic [1:0]       w_code [N_BTN];
  logic [N_BTN-1:0] r_pend_vld;
  logic [1:0]       r_pend_code [N_BTN];
  logic [ID_W-1:0]  r_last;
  logic             w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [N_BTN-1:0] w_gnt_vec;
  logic [N_BTN-1:0] w_drop;
  logic             r_ovf;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [ID_W-1:0]  r_mem_id [FIFO_DEPTH];
  logic [1:0]       r_mem_code [FIFO_DEPTH];
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_can_push;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_in  (btn_in[g]),
      .level   (btn_state[g]),
      .evt_stb (w_stb[g]),
      .evt_code(w_code[g])
    );
  end

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = !w_empty && evt_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still take a push then.
  assign w_can_push = !w_full || w_pop;

  assign evt_valid = !w_empty;
  assign evt_id    = w_empty ? '0 : r_mem_id[r_rd_ptr[AW-1:0]];
  assign evt_code  = w_empty ? 2'd0 : r_mem_code[r_rd_ptr[AW-1:0]];
  assign overflow  = r_ovf;
  assign w_drop    = w_stb & r_pend_vld & ~w_gnt_vec;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_gnt_vec = '0;
    v_idx     = '0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      v_idx = ID_W'((32'(r_last) + k) % N_BTN);
      if (!w_gnt && r_pend_vld[v_idx] && w_can_push) begin
        w_gnt     = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
    if (w_gnt) w_gnt_vec[w_gnt_idx] = 1'b1;
  end

  // Pending slots: a granted slot may reload in the same cycle; otherwise newer events drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_vld <= '0;
      for (int i = 0; i < N_BTN; i++) r_pend_code[i] <= 2'd0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (w_stb[i] && (!r_pend_vld[i] || w_gnt_vec[i])) begin
          r_pend_vld[i]  <= 1'b1;
          r_pend_code[i] <= w_code[i];
        end else if (w_gnt_vec[i]) begin
          r_pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer, FIFO pointers and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last   <= ID_W'(N_BTN - 1);
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_last   <= w_gnt_idx;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (|w_drop)           r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  // FIFO storage; outputs are masked while empty so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_mem_id[r_wr_ptr[AW-1:0]]   <= w_gnt_idx;
      r_mem_code[r_wr_ptr[AW-1:0]] <= r_pend_code[w_gnt_idx];
    end
  end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Multi-channel push-button controller for the input pad ring. Each raw button gets a 2-FF synchroniser, a debounce engine and a press/long-press/release state machine. Events from all channels are arbitrated round-robin into a small event FIFO. The FIFO presents them to the system side over a valid/ready stream, along with the debounced level vector.

## Interface
- `N_BTN`, default 4: number of button channels, 1..16.
- `DB_CYCLES`, default 1000: consecutive cycles of a changed level required to commit it; must be ≥ 2.
- `LONG_CYCLES`, default 50000: consecutive cycles in PRESSED before a LONG event fires; must be > `DB_CYCLES`.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of 2 and ≥ 2.
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `btn_in`, in, N_BTN: raw asynchronous button levels. 1 = pressed.
- `btn_state`, out, N_BTN: debounced, committed levels. Reset value 0.
- `evt_valid`, out, 1: the FIFO head holds an event. Reset value 0.
- `evt_ready`, in, 1: the consumer accepts the head when `evt_valid && evt_ready`.
- `evt_id`, out, max(1,$clog2(N_BTN)): channel index of the head event. Reset value 0.
- `evt_code`, out, 2: event type at the head. PRESS=0, RELEASE=1, LONG=2; 3 is never produced. Reset value 0.
- `overflow`, out, 1: sticky flag indicating an event was dropped. Reset value 0.
- `clr_overflow`, in, 1: synchronous clear of `overflow`.

## Operation
- **Synchroniser:** each channel passes `btn_in` through a 2-FF synchroniser (reset 0) to produce `s`.
- **Debounce counter:**
  - Counts while `s != btn_state[i]`.
  - Clears to 0 on any cycle where `s == btn_state[i]`, so a single bounce restarts the count.
  - When the counter equals `DB_CYCLES-1` with `s` still differing, the new level is committed on that edge and the counter clears.
- **Per-channel FSM** (reset state IDLE):
  - IDLE: committed level 0.
  - PRESSED: committed level 1; hold counter runs.
  - LONG_HELD: committed level 1; LONG already emitted.
  - IDLE → PRESSED on a commit to 1; emits PRESS.
  - PRESSED → LONG_HELD when the hold counter reaches `LONG_CYCLES-1`; emits LONG exactly once.
  - PRESSED → IDLE on a commit to 0; emits RELEASE.
  - LONG_HELD → IDLE on a commit to 0; emits RELEASE.
  - The hold counter clears on entry to PRESSED. It saturates; it never wraps.
- **Pending slot:**
  - Each channel has a 1-entry pending slot: valid bit plus code.
  - A new event arriving while the slot is occupied is dropped and sets `overflow`; the older event is kept.
  - If the slot is granted in the same cycle a new event arrives, the new event loads into the slot and is not dropped.
- **Arbiter:**
  - Round-robin over the pending slots. At most one grant per cycle, and only when the FIFO is not full.
  - The search starts at `last_grant+1` and wraps at `N_BTN-1 → 0`.
  - The pointer updates only on a grant. Its reset value is `N_BTN-1`, so channel 0 wins first.
- **Event FIFO:**
  - Show-ahead FIFO. A full FIFO back-pressures the arbiter; events wait in their pending slots and are not lost there.
  - A push and a pop in the same cycle are both performed, including when the FIFO is full.
- **`overflow`:** if a set condition and `clr_overflow` occur in the same cycle, the set wins.
- **Reset:**
  - Asserting `reset_n` mid-operation clears every FSM, counter, pending slot, the FIFO and the pointers within the same cycle.
  - All outputs return to their reset values. Events not yet popped are discarded.

## Timing
- Let `btn_in` change before edge 0 and stay stable. Then:
  - `s` changes after edge 1.
  - `btn_state` changes and the event enters the pending slot after edge `1+DB_CYCLES`.
  - The event is written to the FIFO after edge `2+DB_CYCLES` if granted.
  - `evt_valid` is visible in the same cycle as the write.
  - Uncontended latency from input to `evt_valid` is `DB_CYCLES+2` edges.
- LONG commits `LONG_CYCLES` edges after the PRESS commit edge.
- Pop: `evt_valid && evt_ready` at edge k removes the head; the next entry, if any, is presented after edge k.
- Sustained throughput is one event per cycle.

## Structure
- Package `btn_evt_pkg` holds:
  - `evt_code_t`, a 2-bit enum: EVT_PRESS, EVT_RELEASE, EVT_LONG.
  - `btn_fsm_t`: IDLE, PRESSED, LONG_HELD.
- Sub-module `btn_channel` contains the synchroniser, debounce counter, hold counter and FSM. Its outputs are `level` and `evt_stb`/`evt_code`.
- The top level instantiates `N_BTN` copies of `btn_channel`, plus the pending slots, arbiter and FIFO.

## Test plan
- **Clean press:** `DB_CYCLES=8`, `btn_in[2]` goes 0→1 and holds → `btn_state[2]` rises 9 edges later; one event `{id=2, PRESS}` with `evt_valid` high at edge 10.
- **Bounce rejection:** `btn_in[0]` toggles 1 for 5 cycles, 0 for 1 cycle, then holds 1 → no commit until 8 consecutive cycles after the bounce; exactly one PRESS.
- **Long press:** `LONG_CYCLES=32`, hold for 100 cycles then release → events in order PRESS, LONG, RELEASE; exactly one LONG.
- **Simultaneous commits:** all 4 channels commit PRESS on the same edge after reset → FIFO order is ids 0,1,2,3. A second wave in the same cycle is then ordered from `last_grant+1`.
- **Back-pressure and overflow:** `FIFO_DEPTH=2`, `evt_ready=0`, channel 1 produces PRESS, RELEASE, PRESS, RELEASE → 2 events in the FIFO, 1 pending, 1 dropped, `overflow=1`. `clr_overflow` clears it. Draining then yields 3 events.
- **Reset mid-operation:** assert `reset_n` low with 2 events queued and channel 3 at debounce count 5 → `evt_valid=0` and `btn_state=0` immediately. After release, no stale events; a re-press takes the full `DB_CYCLES`.
